uart_tx: RTL and testbench

//  Serialises parallel words into asynchronous UART frames on one output line.

---
 rtl/uart_tx_if.sv | 12 +
 rtl/uart_tx.sv | 143 ++++++++++++++
 tb/tb_uart_tx.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Valid/ready word handshake between a producer and the UART transmitter.
`timescale 1ns/1ps
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit after the last data bit.
`timescale 1ns/1ps
module uart_tx #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int DATA_BITS     = 8
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave tx_if,
  output logic     tx_serial,
  output logic     tx_busy
);
  localparam int BAUD_DIV = CLK_FREQUENCY / BAUD_RATE;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BIT_W    = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 serial_q, serial_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 baud_end;
  logic                 accept;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    baud_end = (baud_q == BAUD_LAST);
    accept   = tx_if.tx_valid && ready_q;

    if (state_q != S_IDLE) begin
      baud_d = baud_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_START;
          baud_d   = '0;
          shift_d  = tx_if.tx_data;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_if.tx_data;
`endif
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (baud_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is decoded from the next state so the flop shows each bit on the edge it begins.
    case (state_d)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: serial_d = parity_d;
`endif
      default:  serial_d = 1'b1;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx_if.tx_ready = ready_q;
  assign tx_serial      = serial_q;
  assign tx_busy        = busy_q;
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx; expected line levels come from a frame-bit model of the UART format.
`timescale 1ns/1ps
module tb_uart_tx;
  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DBITS  = 8;
  localparam int BDIV   = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS  = DBITS + 3;
`else
  localparam int NBITS  = DBITS + 2;
`endif
  localparam int FRAME  = NBITS * BDIV;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx_serial, tx_busy;
  int   errors = 0;
  int   checks = 0;

  uart_tx_if #(.DATA_BITS(DBITS)) bus ();

  uart_tx #(
    .CLK_FREQUENCY(CLK_HZ),
    .BAUD_RATE    (BAUD),
    .DATA_BITS    (DBITS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_if    (bus.slave),
    .tx_serial(tx_serial),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  // Expected line level k cycles into a frame carrying word w.
  function automatic logic frame_bit(input logic [DBITS-1:0] w, input int k);
    int b;
    b = k / BDIV;
    if (b == 0) return 1'b0;
    if (b <= DBITS) return w[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == DBITS + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    reset = 1'b1;
    repeat (3) begin
      step();
      checks++;
      if ({tx_serial, bus.tx_ready, tx_busy} !== 3'b100) begin
        errors++;
        $display("FAIL reset_hold got=%b exp=100", {tx_serial, bus.tx_ready, tx_busy});
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      checks++;
      if ({tx_serial, bus.tx_ready, tx_busy} !== 3'b110) begin
        errors++;
        $display("FAIL idle cyc=%0d got=%b exp=110", i, {tx_serial, bus.tx_ready, tx_busy});
      end
    end
  endtask

  task automatic test_single();
    logic [DBITS-1:0] w;
    w = 8'h55;
    bus.tx_data = w; bus.tx_valid = 1'b1;
    step();
    bus.tx_valid = 1'b0;
    checks++;
    if ({bus.tx_ready, tx_busy} !== 2'b01) begin
      errors++;
      $display("FAIL single_accept got=%b exp=01", {bus.tx_ready, tx_busy});
    end
    for (int k = 0; k < FRAME; k++) begin
      checks++;
      if (tx_serial !== frame_bit(w, k)) begin
        errors++;
        $display("FAIL single_line k=%0d got=%b exp=%b", k, tx_serial, frame_bit(w, k));
      end
      step();
    end
    checks++;
    if ({tx_serial, bus.tx_ready, tx_busy} !== 3'b110) begin
      errors++;
      $display("FAIL single_end got=%b exp=110", {tx_serial, bus.tx_ready, tx_busy});
    end
  endtask

  task automatic test_back_to_back();
    logic [DBITS-1:0] w [2];
    w[0] = 8'hA3; w[1] = 8'h0F;
    bus.tx_data = w[0]; bus.tx_valid = 1'b1;
    step();
    bus.tx_data = w[1];
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < FRAME; k++) begin
        checks++;
        if (tx_serial !== frame_bit(w[f], k)) begin
          errors++;
          $display("FAIL b2b_line f=%0d k=%0d got=%b exp=%b", f, k, tx_serial, frame_bit(w[f], k));
        end
        step();
      end
      checks++;
      if ({tx_serial, bus.tx_ready} !== 2'b11) begin
        errors++;
        $display("FAIL b2b_gap f=%0d got=%b exp=11", f, {tx_serial, bus.tx_ready});
      end
      if (f == 0) step();
      bus.tx_valid = 1'b0;
    end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({tx_serial, tx_busy} !== 2'b10) begin
        errors++;
        $display("FAIL b2b_no_third cyc=%0d got=%b exp=10", i, {tx_serial, tx_busy});
      end
    end
  endtask

  task automatic test_ignored();
    logic [DBITS-1:0] w;
    w = DBITS'($urandom);
    bus.tx_data = w; bus.tx_valid = 1'b1;
    step();
    bus.tx_valid = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      if (k == 25) begin bus.tx_data = 8'hFF; bus.tx_valid = 1'b1; end
      if (k == 26) bus.tx_valid = 1'b0;
      checks++;
      if (tx_serial !== frame_bit(w, k)) begin
        errors++;
        $display("FAIL ignored_line k=%0d got=%b exp=%b", k, tx_serial, frame_bit(w, k));
      end
      step();
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({tx_serial, tx_busy} !== 2'b10) begin
        errors++;
        $display("FAIL ignored_after cyc=%0d got=%b exp=10", i, {tx_serial, tx_busy});
      end
      step();
    end
  endtask

  task automatic test_reset_midframe();
    logic [DBITS-1:0] w;
    w = 8'h00;
    bus.tx_data = w; bus.tx_valid = 1'b1;
    step();
    bus.tx_valid = 1'b0;
    for (int k = 0; k < 37; k++) begin
      checks++;
      if (tx_serial !== frame_bit(w, k)) begin
        errors++;
        $display("FAIL midrst_line k=%0d got=%b exp=%b", k, tx_serial, frame_bit(w, k));
      end
      step();
    end
    reset = 1'b1;
    step();
    checks++;
    if ({tx_serial, bus.tx_ready, tx_busy} !== 3'b100) begin
      errors++;
      $display("FAIL midrst_abort got=%b exp=100", {tx_serial, bus.tx_ready, tx_busy});
    end
    step();
    reset = 1'b0;
    step();
    checks++;
    if ({tx_serial, bus.tx_ready, tx_busy} !== 3'b110) begin
      errors++;
      $display("FAIL midrst_release got=%b exp=110", {tx_serial, bus.tx_ready, tx_busy});
    end
    w = 8'h81;
    bus.tx_data = w; bus.tx_valid = 1'b1;
    step();
    bus.tx_valid = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      checks++;
      if (tx_serial !== frame_bit(w, k)) begin
        errors++;
        $display("FAIL midrst_new k=%0d got=%b exp=%b", k, tx_serial, frame_bit(w, k));
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [DBITS-1:0] w;
    int gap;
    for (int n = 0; n < 8; n++) begin
      w = DBITS'($urandom);
      gap = $urandom_range(0, 3);
      bus.tx_data = w; bus.tx_valid = 1'b1;
      step();
      bus.tx_valid = 1'b0;
      bus.tx_data = DBITS'($urandom);
      for (int k = 0; k < FRAME; k++) begin
        checks++;
        if (tx_serial !== frame_bit(w, k)) begin
          errors++;
          $display("FAIL rand_line n=%0d w=%h k=%0d got=%b exp=%b", n, w, k, tx_serial, frame_bit(w, k));
        end
        step();
      end
      checks++;
      if ({tx_serial, bus.tx_ready, tx_busy} !== 3'b110) begin
        errors++;
        $display("FAIL rand_end n=%0d got=%b exp=110", n, {tx_serial, bus.tx_ready, tx_busy});
      end
      repeat (gap) step();
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [DBITS-1:0] w [2];
    logic             par [2];
    w[0] = 8'h07; par[0] = 1'b1;
    w[1] = 8'h03; par[1] = 1'b0;
    for (int f = 0; f < 2; f++) begin
      bus.tx_data = w[f]; bus.tx_valid = 1'b1;
      step();
      bus.tx_valid = 1'b0;
      for (int k = 0; k < FRAME; k++) begin
        checks++;
        if (tx_serial !== frame_bit(w[f], k)) begin
          errors++;
          $display("FAIL parity_line f=%0d k=%0d got=%b exp=%b", f, k, tx_serial, frame_bit(w[f], k));
        end
        if (k == (DBITS + 1) * BDIV + BDIV / 2) begin
          checks++;
          if (tx_serial !== par[f]) begin
            errors++;
            $display("FAIL parity_bit f=%0d got=%b exp=%b", f, tx_serial, par[f]);
          end
        end
        step();
      end
      checks++;
      if ({bus.tx_ready, tx_busy} !== 2'b10) begin
        errors++;
        $display("FAIL parity_len f=%0d got=%b exp=10", f, {bus.tx_ready, tx_busy});
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignored();
    test_reset_midframe();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
